// File: rtl/flush_controller.sv
`default_nettype none
// ============================================================================
//  Module      : flush_controller
//  Description : Sequences recovery after a branch misprediction. It waits for
//                an in-flight committed store to drain, holds a multi-cycle
//                flush to the back end, then issues a one-cycle redirect to
//                fetch.
//  Ports       : clk, reset         - clock, asynchronous active-high reset
//                mispredicted       - misprediction strobe (sampled in IDLE)
//                pc_update[31:0]    - correct PC, captured with mispredicted
//                store_busy         - data memory completing a committed store
//                flush              - squash ROB/RS/LSQ/FU scheduler/FUs
//                fetch_hold         - stall fetch and fetch/issue register
//                redirect_valid     - one-cycle load of redirect_pc into PC
//                redirect_pc[31:0]  - captured target PC
//                busy               - recovery in progress
//                drain_timeout      - sticky, DRAIN ended on timeout
//                recover_count[7:0] - completed recoveries, wraps at 256
//  Revision    : 1.0 - initial release
// ============================================================================
module flush_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mispredicted,
    input  logic [31:0] pc_update,
    input  logic        store_busy,
    output logic        flush,
    output logic        fetch_hold,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        drain_timeout,
    output logic [7:0]  recover_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] c_drain_last = 8'(DRAIN_MAX - 1);
    localparam logic [3:0] c_flush_last = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_drain_cnt;
    logic [3:0]  r_flush_cnt;
    logic [31:0] r_target;
    logic        r_flush;
    logic        r_fetch_hold;
    logic        r_redirect_valid;
    logic        r_busy;
    logic        r_drain_timeout;
    logic [7:0]  r_recover_count;

    // Outputs are registered alongside the state: every transition below
    // loads the output values belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_drain_cnt      <= 8'd0;
            r_flush_cnt      <= 4'd0;
            r_target         <= 32'h0;
            r_flush          <= 1'b0;
            r_fetch_hold     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_drain_timeout  <= 1'b0;
            r_recover_count  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mispredicted) begin
                        r_target     <= pc_update;
                        r_fetch_hold <= 1'b1;
                        r_busy       <= 1'b1;
                        if (store_busy) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= 8'd0;
                        end else begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= 4'd0;
                            r_flush     <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The normal exit is tested first so a store finishing on
                    // the last allowed cycle does not count as a timeout.
                    if (!store_busy) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= 4'd0;
                        r_flush     <= 1'b1;
                    end else if (r_drain_cnt == c_drain_last) begin
                        r_state         <= S_FLUSH;
                        r_flush_cnt     <= 4'd0;
                        r_flush         <= 1'b1;
                        r_drain_timeout <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 4'd1;
                    if (r_flush_cnt == c_flush_last) begin
                        r_state          <= S_REDIRECT;
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    r_state          <= S_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_fetch_hold     <= 1'b0;
                    r_busy           <= 1'b0;
                    r_recover_count  <= r_recover_count + 8'd1;
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_flush          <= 1'b0;
                    r_fetch_hold     <= 1'b0;
                    r_redirect_valid <= 1'b0;
                    r_busy           <= 1'b0;
                end
            endcase
        end
    end

    assign flush          = r_flush;
    assign fetch_hold     = r_fetch_hold;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_target;
    assign busy           = r_busy;
    assign drain_timeout  = r_drain_timeout;
    assign recover_count  = r_recover_count;

endmodule
`default_nettype wire
